// File: rtl/addsub_pkg.sv
// Shared operation encoding and saturation-limit helpers for the add/sub accumulator pipeline.
package addsub_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'b00,
        OP_SUB     = 2'b01,
        OP_ACC_ADD = 2'b10,
        OP_ACC_SUB = 2'b11
    } addsub_op_t;

    // Limits are returned 32 bits wide; callers truncate to their own width.
    function automatic logic [31:0] sat_max(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return 32'hFFFF_FFFF << (w - 1);
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational two's-complement adder/subtractor with unsigned carry-out and signed overflow.
module addsub_core #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         ovf
);

    logic [W-1:0] y_eff;

    // Subtraction is x + ~y + 1, so carry = 1 means no borrow.
    assign y_eff        = sub ? ~y : y;
    assign {carry, sum} = {1'b0, x} + {1'b0, y_eff} + (W + 1)'(sub);
    assign ovf          = (x[W-1] == y_eff[W-1]) && (sum[W-1] != x[W-1]);

endmodule

// File: rtl/addsub_acc_pipe.sv
// Two-stage add/sub pipeline with accumulator, valid/ready handshakes and sign-magnitude output.
// Define ADDSUB_SAT_EN to clamp overflowing results instead of wrapping modulo 2^W.
module addsub_acc_pipe
    import addsub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         clr_acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res,
    output logic [W-1:0] mag,
    output logic         neg,
    output logic         carry,
    output logic         ovf,
    output logic         ovf_sticky
);

    logic         s1_valid;
    addsub_op_t   s1_op;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [W-1:0] acc;

    logic         accept;
    logic         s2_load;
    logic         is_acc;
    logic         is_sub;
    logic [W-1:0] acc_eff;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] sum_n;
    logic         carry_n;
    logic         ovf_n;
    logic [W-1:0] res_n;
    logic [W-1:0] mag_n;

    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);

    assign is_acc  = (s1_op == OP_ACC_ADD) || (s1_op == OP_ACC_SUB);
    assign is_sub  = (s1_op == OP_SUB) || (s1_op == OP_ACC_SUB);
    // A coincident clear takes effect before the accumulating op reads acc.
    assign acc_eff = clr_acc ? '0 : acc;
    assign x       = is_acc ? acc_eff : s1_a;
    assign y       = is_acc ? s1_a : s1_b;

    addsub_core #(.W(W)) u_core (
        .x     (x),
        .y     (y),
        .sub   (is_sub),
        .sum   (sum_n),
        .carry (carry_n),
        .ovf   (ovf_n)
    );

`ifdef ADDSUB_SAT_EN
    localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

    // NOTE: every variable gets a default first so always_comb never infers a latch.
    always_comb begin
        res_n = sum_n;
        if (ovf_n) res_n = x[W-1] ? SAT_MIN : SAT_MAX;
    end
`else
    assign res_n = sum_n;
`endif

    // The most negative value maps to 2^(W-1), which still fits unsigned in W bits.
    assign mag_n = res_n[W-1] ? (~res_n + W'(1)) : res_n;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: request payload is qualified by s1_valid, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            s1_op <= addsub_op_t'(op);
            s1_a  <= a;
            s1_b  <= b;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            res       <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            res       <= res_n;
            mag       <= mag_n;
            neg       <= res_n[W-1];
            carry     <= carry_n;
            ovf       <= ovf_n;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (s2_load && is_acc) acc <= res_n;
            else if (clr_acc)      acc <= '0;

            if (s2_load)      ovf_sticky <= (ovf_sticky && !clr_acc) || ovf_n;
            else if (clr_acc) ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Scoreboard bench for addsub_acc_pipe at W=4; an integer reference model predicts each result.
module tb_addsub_acc_pipe;

    localparam int W = 4;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] mag;
        logic       neg;
        logic       carry;
        logic       ovf;
        logic       sticky;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         clr_acc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] res;
    logic [W-1:0] mag;
    logic         neg;
    logic         carry;
    logic         ovf;
    logic         ovf_sticky;

    int   n_checks = 0;
    int   n_errors = 0;
    int   accepts = 0;
    int   m_acc = 0;
    logic m_sticky = 1'b0;
    logic mon_en = 1'b0;
    logic rnd_done = 1'b0;
    exp_t sb[$];

    addsub_acc_pipe #(.W(W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .clr_acc    (clr_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res        (res),
        .mag        (mag),
        .neg        (neg),
        .carry      (carry),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    function automatic int sx(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Reference model: plain integer arithmetic, applied in acceptance order.
    task automatic model_push(input logic [1:0] o, input logic [3:0] xa, input logic [3:0] xb,
                              input logic clr);
        int   xs, ys, r, rv, av;
        exp_t e;
        if (clr) begin
            m_acc    = 0;
            m_sticky = 1'b0;
        end
        xs = o[1] ? m_acc : sx(xa);
        ys = o[1] ? sx(xa) : sx(xb);
        r  = o[0] ? xs - ys : xs + ys;
        e.carry = o[0] ? ((xs & 15) >= (ys & 15)) : (((xs & 15) + (ys & 15)) > 15);
        e.ovf   = (r > 7) || (r < -8);
`ifdef ADDSUB_SAT_EN
        rv = (r > 7) ? 7 : ((r < -8) ? -8 : r);
`else
        rv = ((r + 8) & 15) - 8;
`endif
        av       = (rv < 0) ? -rv : rv;
        e.res    = rv[3:0];
        e.mag    = av[3:0];
        e.neg    = (rv < 0);
        if (o[1]) m_acc = rv;
        m_sticky = m_sticky | e.ovf;
        e.sticky = m_sticky;
        sb.push_back(e);
    endtask

    task automatic send(input logic [1:0] o, input logic [3:0] xa, input logic [3:0] xb,
                        input logic clr);
        int n;
        n = 0;
        in_valid = 1'b1;
        op = o;
        a  = xa;
        b  = xb;
        forever begin
            @(negedge CLK);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 32'(n), 0);
                finish_sim();
            end
        end
        @(posedge CLK);
        #1;
        accepts++;
        model_push(o, xa, xb, clr);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_acc();
        idle(3);
        clr_acc = 1'b1;
        @(posedge CLK);
        #1;
        clr_acc  = 1'b0;
        m_acc    = 0;
        m_sticky = 1'b0;
    endtask

    // Output monitor: scoreboard compare on each transfer, stability check while stalled.
    initial begin
        logic       held;
        logic [3:0] h_res, h_mag;
        logic [3:0] h_flags;
        exp_t       e;
        held = 1'b0;
        h_res = '0;
        h_mag = '0;
        h_flags = '0;
        forever begin
            @(negedge CLK);
            if (!mon_en || !RST_N) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 32'(out_valid), 1);
                    check("hold_res", 32'(res), 32'(h_res));
                    check("hold_mag", 32'(mag), 32'(h_mag));
                    check("hold_flags", 32'({neg, carry, ovf, ovf_sticky}), 32'(h_flags));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 32'(res), 32'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        check("res", 32'(res), 32'(e.res));
                        check("mag", 32'(mag), 32'(e.mag));
                        check("neg", 32'(neg), 32'(e.neg));
                        check("carry", 32'(carry), 32'(e.carry));
                        check("ovf", 32'(ovf), 32'(e.ovf));
                        check("ovf_sticky", 32'(ovf_sticky), 32'(e.sticky));
                    end
                end
                held    = out_valid && !out_ready;
                h_res   = res;
                h_mag   = mag;
                h_flags = {neg, carry, ovf, ovf_sticky};
            end
        end
    end

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_outputs", 32'({res, mag, neg, carry, ovf, ovf_sticky}), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge CLK);
        RST_N = 1'b1;
        mon_en = 1'b1;
        @(posedge CLK);
        #1;

        // Directed add/sub, including both overflow directions
        send(2'b00, 4'd7, 4'd1, 1'b0);
        send(2'b01, 4'd3, 4'd5, 1'b0);
        send(2'b01, 4'd5, 4'd3, 1'b0);
        send(2'b00, 4'd8, 4'd8, 1'b0);
        send(2'b01, 4'd8, 4'd1, 1'b0);
        send(2'b00, 4'd15, 4'd1, 1'b0);

        // Back-to-back accumulation with sticky overflow
        clear_acc();
        send(2'b10, 4'd3, 4'd0, 1'b0);
        send(2'b10, 4'd3, 4'd0, 1'b0);
        send(2'b10, 4'd3, 4'd0, 1'b0);
        send(2'b00, 4'd1, 4'd1, 1'b0);
        idle(3);

        // Backpressure: S1 and S2 fill, then in_ready drops
        out_ready = 1'b0;
        accepts = 0;
        fork
            begin
                send(2'b00, 4'd1, 4'd2, 1'b0);
                send(2'b00, 4'd3, 4'd4, 1'b0);
                send(2'b01, 4'd2, 4'd6, 1'b0);
                send(2'b00, 4'd6, 4'd5, 1'b0);
            end
            begin
                repeat (5) @(posedge CLK);
                @(negedge CLK);
                check("bp_accepts", 32'(accepts), 2);
                check("bp_in_ready", 32'(in_ready), 0);
                @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Clear coincident with the S2 load of ACC_SUB: acc 5 -> clear -> 0-2
        clear_acc();
        send(2'b10, 4'd5, 4'd0, 1'b0);
        send(2'b11, 4'd2, 4'd0, 1'b1);
        clr_acc = 1'b1;
        @(posedge CLK);
        #1;
        clr_acc = 1'b0;
        send(2'b10, 4'd0, 4'd0, 1'b0);
        idle(3);

        // Random stream with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 1'b0);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(4);
        check("mid_drain", 32'(sb.size()), 0);

        // Reset while S1 and S2 are both full
        out_ready = 1'b0;
        send(2'b00, 4'd7, 4'd1, 1'b0);
        send(2'b00, 4'd2, 4'd2, 1'b0);
        check("full_s2_valid", 32'(out_valid), 1);
        check("full_in_ready", 32'(in_ready), 0);
        mon_en = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_outputs", 32'({res, mag, neg, carry, ovf, ovf_sticky}), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        sb.delete();
        m_acc    = 0;
        m_sticky = 1'b0;
        @(negedge CLK);
        check("post_rst_no_valid", 32'(out_valid), 0);
        RST_N = 1'b1;
        out_ready = 1'b1;
        mon_en = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_quiet", 32'(out_valid), 0);
        in_valid = 1'b1;
        op = 2'b01;
        a  = 4'd6;
        b  = 4'd2;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        model_push(2'b01, 4'd6, 4'd2, 1'b0);
        check("lat_edge_k", 32'(out_valid), 0);
        @(posedge CLK);
        #1;
        check("lat_edge_k1", 32'(out_valid), 1);

        // Final drain
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge CLK);
        @(negedge CLK);
        check("drain", 32'(sb.size()), 0);
        finish_sim();
    end

    initial begin
        #200000;
        check("global_timeout", 0, 1);
        finish_sim();
    end

endmodule
